// File: rtl/seven_segment_monitor_if.sv
// Bundle of the 7-segment read-back signals: the observed segment bus and
// error clear going in, the decoded digit, period measurement and sticky
// error flags coming back out.
interface seven_segment_monitor_if #(
  parameter int PERIOD_W = 24
);
  logic [6:0]          seg_in;
  logic                clear_errors;
  logic [3:0]          digit_out;
  logic                digit_valid;
  logic [PERIOD_W-1:0] period_out;
  logic                period_valid;
  logic                seq_error;
  logic                invalid_error;

  // Side that drives the segment bus and watches the results
  modport master (
    output seg_in, clear_errors,
    input  digit_out, digit_valid, period_out, period_valid,
           seq_error, invalid_error
  );

  // The monitor itself
  modport slave (
    input  seg_in, clear_errors,
    output digit_out, digit_valid, period_out, period_valid,
           seq_error, invalid_error
  );
endinterface

// File: rtl/seven_segment_monitor.sv
// Seven-segment read-back monitor: turns a segment drive bus back into a BCD
// digit after a stability filter, flags illegal patterns and out-of-order
// counting, and measures the clock distance between successive digits.
module seven_segment_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W      = 24
) (
  input logic                   clk,
  input logic                   reset,
  seven_segment_monitor_if.slave bus
);

  localparam int SCNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SCNT_W-1:0]   SCNT_MAX = SCNT_W'(STABLE_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] PCNT_ONE = PERIOD_W'(1);

  logic [6:0]          seg_q;
  logic [6:0]          cand;
  logic [SCNT_W-1:0]   scnt;
  logic [6:0]          acc_pat;
  logic                acc_none;
  logic                prev_valid;
  logic [3:0]          prev_d;
  logic [PERIOD_W-1:0] pcnt;

  logic                accept;
  logic [3:0]          dec_digit;
  logic                dec_legal;
  logic [3:0]          expected_d;

  // A candidate is accepted once it has been stable long enough and differs
  // from what was last accepted, so a held pattern produces a single event.
  always_comb begin
    accept     = (seg_q == cand) && (scnt == SCNT_MAX) &&
                 (acc_none || (cand != acc_pat));
    expected_d = (prev_d == 4'd9) ? 4'd0 : prev_d + 4'd1;
  end

  // Segment pattern to digit lookup; anything outside the table is not a digit.
  always_comb begin
    dec_digit = 4'd0;
    dec_legal = 1'b1;
    case (cand)
      7'h3F:   dec_digit = 4'd0;
      7'h06:   dec_digit = 4'd1;
      7'h5B:   dec_digit = 4'd2;
      7'h4F:   dec_digit = 4'd3;
      7'h66:   dec_digit = 4'd4;
      7'h6D:   dec_digit = 4'd5;
      7'h7C:   dec_digit = 4'd6;
      7'h07:   dec_digit = 4'd7;
      7'h7F:   dec_digit = 4'd8;
      7'h67:   dec_digit = 4'd9;
      default: dec_legal = 1'b0;
    endcase
  end

  // Input sync register and glitch filter: any change restarts the stability count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_q <= '0;
      cand  <= '0;
      scnt  <= '0;
    end else begin
      seg_q <= bus.seg_in;
      if (seg_q != cand) begin
        cand <= seg_q;
        scnt <= '0;
      end else if (scnt < SCNT_MAX) begin
        scnt <= scnt + 1'b1;
      end
    end
  end

  // Accept-event handling: decode, sequence check, period capture and sticky errors.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_pat           <= '0;
      acc_none          <= 1'b1;
      prev_valid        <= 1'b0;
      prev_d            <= '0;
      pcnt              <= '0;
      bus.digit_out     <= '0;
      bus.digit_valid   <= 1'b0;
      bus.period_out    <= '0;
      bus.period_valid  <= 1'b0;
      bus.seq_error     <= 1'b0;
      bus.invalid_error <= 1'b0;
    end else begin
      bus.period_valid <= 1'b0;
      if (pcnt != PCNT_MAX) begin
        pcnt <= pcnt + 1'b1;
      end
      if (bus.clear_errors) begin
        bus.seq_error     <= 1'b0;
        bus.invalid_error <= 1'b0;
      end
      if (accept) begin
        acc_none <= 1'b0;
        acc_pat  <= cand;
        if (dec_legal) begin
          bus.digit_out   <= dec_digit;
          bus.digit_valid <= 1'b1;
          pcnt            <= PCNT_ONE;
          if (prev_valid) begin
            bus.period_out   <= pcnt;
            bus.period_valid <= 1'b1;
            if (dec_digit != expected_d) begin
              bus.seq_error <= 1'b1;
            end
          end
          prev_valid <= 1'b1;
          prev_d     <= dec_digit;
        end else begin
          bus.digit_valid <= 1'b0;
          prev_valid      <= 1'b0;
          if (cand != 7'h00) begin
            bus.invalid_error <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_monitor.sv
// Bench for seven_segment_monitor: directed scenarios plus randomized segment
// streams. A behavioural model predicts every visible output change and queues
// it; an independent monitor pops and compares whenever the outputs move.
module tb_seven_segment_monitor;

  localparam int S  = 4;
  localparam int PW = 8;
  localparam logic [6:0] LUT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

  typedef struct packed {
    logic [3:0]    digit;
    logic          dv;
    logic [PW-1:0] period;
    logic          pv;
    logic          se;
    logic          ie;
  } obs_t;

  logic clk = 1'b0;
  logic reset;

  seven_segment_monitor_if #(.PERIOD_W(PW)) bus ();

  seven_segment_monitor #(.STABLE_CYCLES(S), .PERIOD_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  obs_t       expq[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  bit         mon_en = 1'b0;
  logic [6:0] last_pat = 7'h00;

  // Reference model state: what the digit stream means, not how it is built
  bit         m_acc_none;
  logic [6:0] m_acc_pat;
  bit         m_prev_valid;
  int         m_prev_d;
  int         m_last_legal;
  obs_t       m_vis;

  function automatic obs_t strip_pv(obs_t o);
    o.pv = 1'b0;
    return o;
  endfunction

  function automatic int decode(logic [6:0] p);
    for (int i = 0; i < 10; i++) if (LUT[i] == p) return i;
    return -1;
  endfunction

  // Queue the new visible state when it differs or carries a period pulse
  task automatic publish(obs_t old);
    if (strip_pv(m_vis) != strip_pv(old) || m_vis.pv) expq.push_back(m_vis);
    m_vis.pv = 1'b0;
  endtask

  task automatic model_reset();
    obs_t old;
    old          = m_vis;
    m_vis        = '0;
    m_acc_none   = 1'b1;
    m_acc_pat    = 7'h00;
    m_prev_valid = 1'b0;
    m_prev_d     = 0;
    m_last_legal = 0;
    publish(old);
  endtask

  task automatic model_clear();
    obs_t old;
    old      = m_vis;
    m_vis.se = 1'b0;
    m_vis.ie = 1'b0;
    publish(old);
  endtask

  task automatic model_accept(logic [6:0] pat, int start, bit clr);
    obs_t old;
    int   d;
    int   diff;
    old = m_vis;
    if (clr) begin
      m_vis.se = 1'b0;
      m_vis.ie = 1'b0;
    end
    m_acc_none = 1'b0;
    m_acc_pat  = pat;
    d = decode(pat);
    if (d >= 0) begin
      if (m_prev_valid) begin
        if (d != (m_prev_d + 1) % 10) m_vis.se = 1'b1;
        diff         = start - m_last_legal;
        m_vis.period = (diff > (1 << PW) - 1) ? '1 : PW'(diff);
        m_vis.pv     = 1'b1;
      end
      m_vis.digit  = 4'(d);
      m_vis.dv     = 1'b1;
      m_last_legal = start;
      m_prev_valid = 1'b1;
      m_prev_d     = d;
    end else begin
      m_vis.dv     = 1'b0;
      m_prev_valid = 1'b0;
      if (pat != 7'h00) m_vis.ie = 1'b1;
    end
    publish(old);
  endtask

  task automatic check_output(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Hold one pattern for len cycles; mode 1 pulses clear on the second cycle,
  // mode 2 pulses it on the cycle sampled at the accept edge.
  task automatic apply_stimulus(logic [6:0] pat, int len, int mode);
    int  start;
    bit  accepted;
    bit  clr1;
    bit  clr2;
    start    = cyc + 1;
    accepted = (len >= S + 1) && (m_acc_none || pat != m_acc_pat);
    clr1     = (mode == 1) && (len >= 2);
    clr2     = (mode == 2) && (len >= S + 2);
    if (clr1) model_clear();
    if (accepted) model_accept(pat, start, clr2);
    else if (clr2) model_clear();
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      reset            = 1'b1;
      bus.seg_in       = pat;
      bus.clear_errors = (clr1 && i == 1) || (clr2 && i == S + 1);
      cyc++;
    end
    last_pat = pat;
  endtask

  task automatic do_reset(int n);
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset            = 1'b0;
      bus.clear_errors = 1'b0;
      cyc++;
    end
    last_pat = 7'h00;
  endtask

  function automatic logic [6:0] pick_pattern();
    logic [6:0] p;
    int         r;
    do begin
      r = $urandom_range(0, 9);
      if (r < 5)      p = m_prev_valid ? LUT[(m_prev_d + 1) % 10] : LUT[$urandom_range(0, 9)];
      else if (r < 7) p = LUT[$urandom_range(0, 9)];
      else if (r < 8) p = 7'h00;
      else            p = 7'($urandom_range(0, 127));
    end while (p == last_pat);
    return p;
  endfunction

  function automatic int pick_len();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3)  return $urandom_range(1, S);
    if (r < 4)  return S + 1;
    if (r < 9)  return $urandom_range(S + 2, 60);
    return $urandom_range(250, 320);
  endfunction

  obs_t mon_cur;
  obs_t mon_want;
  obs_t last_seen = '0;

  // Monitor: whenever the outputs change (or a period pulse appears) the
  // oldest prediction is popped and compared.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur.digit  = bus.digit_out;
      mon_cur.dv     = bus.digit_valid;
      mon_cur.period = bus.period_out;
      mon_cur.pv     = bus.period_valid;
      mon_cur.se     = bus.seq_error;
      mon_cur.ie     = bus.invalid_error;
      if (strip_pv(mon_cur) != strip_pv(last_seen) || mon_cur.pv) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_event: got d=%0d dv=%0d per=%0d pv=%0d se=%0d ie=%0d, none expected",
                   mon_cur.digit, mon_cur.dv, mon_cur.period, mon_cur.pv, mon_cur.se, mon_cur.ie);
        end else begin
          mon_want = expq.pop_front();
          if (mon_cur !== mon_want) begin
            bad++;
            $display("[TB] FAIL output_event at cycle %0d: got d=%0d dv=%0d per=%0d pv=%0d se=%0d ie=%0d, want d=%0d dv=%0d per=%0d pv=%0d se=%0d ie=%0d",
                     cyc, mon_cur.digit, mon_cur.dv, mon_cur.period, mon_cur.pv, mon_cur.se, mon_cur.ie,
                     mon_want.digit, mon_want.dv, mon_want.period, mon_want.pv, mon_want.se, mon_want.ie);
          end
        end
        last_seen = strip_pv(mon_cur);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int start;
    // Reset held with a digit on the bus: everything must read zero
    reset            = 1'b0;
    bus.seg_in       = 7'h7F;
    bus.clear_errors = 1'b0;
    m_vis            = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_outputs",
                 {20'd0, bus.digit_out, bus.digit_valid, bus.period_out,
                  bus.period_valid, bus.seq_error, bus.invalid_error}, 32'd0);
    mon_en = 1'b1;

    // First digit after reset appears exactly STABLE_CYCLES+2 edges later
    start = cyc + 1;
    model_accept(7'h7F, start, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 6) check_output("first_accept_edge5_dv", {31'd0, bus.digit_valid}, 32'd0);
      if (i == 7) check_output("first_accept_edge6",
                               {26'd0, bus.digit_out, bus.digit_valid, bus.period_valid},
                               {26'd0, 4'd8, 1'b1, 1'b0});
      reset            = 1'b1;
      bus.seg_in       = 7'h7F;
      bus.clear_errors = 1'b0;
      cyc++;
    end
    last_pat = 7'h7F;

    // Full count 0..9 and wrap to 0, 100 cycles per digit
    do_reset(2);
    for (int i = 0; i <= 10; i++) apply_stimulus(LUT[i % 10], 100, 0);

    // Short glitch rejected, boundary-length glitch accepted
    do_reset(2);
    apply_stimulus(7'h3F, 20, 0);
    apply_stimulus(7'h06, 3, 0);
    apply_stimulus(7'h3F, 20, 0);
    apply_stimulus(7'h06, S + 1, 0);
    apply_stimulus(7'h5B, 10, 0);

    // Sequence error, sticky, clear, clear coinciding with a new error
    do_reset(2);
    apply_stimulus(7'h4F, 10, 0);
    apply_stimulus(7'h6D, 10, 0);
    apply_stimulus(7'h7C, 10, 0);
    apply_stimulus(7'h07, 10, 1);
    apply_stimulus(7'h7F, 10, 2);
    apply_stimulus(7'h3F, 10, 2);

    // Invalid pattern breaks the sequence and period chain
    do_reset(2);
    apply_stimulus(7'h01, 10, 0);
    apply_stimulus(7'h66, 10, 0);
    apply_stimulus(7'h6D, 10, 0);

    // Period saturation, then reset in the middle of a candidate hold
    do_reset(2);
    apply_stimulus(7'h06, 300, 0);
    apply_stimulus(7'h5B, 10, 0);
    apply_stimulus(7'h4F, 2, 0);
    do_reset(3);
    apply_stimulus(7'h66, 10, 0);

    // Randomized segment streams with occasional clears and resets
    for (int n = 0; n < 150; n++) begin
      int r;
      int mode;
      r    = $urandom_range(0, 15);
      mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      apply_stimulus(pick_pattern(), pick_len(), mode);
      if ($urandom_range(0, 39) == 0) begin
        apply_stimulus(pick_pattern(), $urandom_range(1, S), 0);
        do_reset($urandom_range(1, 3));
      end
    end

    // Let the last predictions drain
    @(negedge clk);
    bus.clear_errors = 1'b0;
    for (int w = 0; w < 20 && expq.size() > 0; w++) @(negedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: %0d predicted events never seen, want 0", expq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
